// File: rtl/seq_detector_gen.sv
// Serial-bit sequence detector: fixed 01[0*]1 FSM plus programmable pattern matcher, BCD match counter, 7-seg drive.
// Latency: z is combinational on the current bit; count_bcd/disp update on the same rising edge / one cycle after z.
// Backpressure: none; ena=0 freezes detector state while pattern load and count clear still take effect.
module seq_detector_gen #(
    parameter int PAT_LEN    = 8,
    parameter int NUM_DIGITS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         sig_to_test,
    input  logic                         mode,
    input  logic                         overlap,
    input  logic                         pat_load,
    input  logic [PAT_LEN-1:0]           pat_value,
    input  logic [$clog2(PAT_LEN+1)-1:0] pat_len,
    input  logic                         count_clr,
    output logic                         z,
    output logic [4*NUM_DIGITS-1:0]      count_bcd,
    output logic [7*NUM_DIGITS-1:0]      disp,
    output logic                         saturated
);
    localparam int LW = $clog2(PAT_LEN+1);

    typedef enum logic [1:0] {IDLE, S_0, S_01, S_010} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_fix_match;

    logic [PAT_LEN-2:0]      r_hist;
    logic [LW-1:0]           r_fill;
    logic [LW-1:0]           r_pat_len;
    logic [PAT_LEN-1:0]      r_pat;
    logic [PAT_LEN-1:0]      w_window;
    logic [PAT_LEN-1:0]      w_mask;
    logic                    w_len_ok;
    logic                    w_fill_ok;
    logic                    w_prog_match;

    logic [4*NUM_DIGITS-1:0] r_count;
    logic [4*NUM_DIGITS-1:0] w_count_inc;
    logic                    w_at_max;
    logic                    w_carry;
    logic [3:0]              w_digit;

    // Fixed engine: next state and Mealy match; a load forces IDLE, ena=0 holds the state.
    always_comb begin
        w_state_nxt = r_state;
        w_fix_match = 1'b0;
        case (r_state)
            IDLE:  w_state_nxt = sig_to_test ? IDLE : S_0;
            S_0:   w_state_nxt = sig_to_test ? S_01 : S_0;
            S_01: begin
                if (sig_to_test) begin
                    w_fix_match = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = S_010;
                end
            end
            S_010: begin
                if (sig_to_test) begin
                    w_fix_match = 1'b1;
                    w_state_nxt = overlap ? S_01 : IDLE;
                end else begin
                    w_state_nxt = S_010;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (pat_load) begin
            w_state_nxt = IDLE;
        end else if (!ena) begin
            w_state_nxt = r_state;
        end
    end

    // Fixed engine state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Newest bit sits at the LSB, so the window lines up with pat_value[pat_len-1:0].
    assign w_window = {r_hist, sig_to_test};

    // Only the low pat_len bits of the window take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            w_mask[i] = (LW'(i) < r_pat_len);
        end
    end

    assign w_len_ok     = (r_pat_len != '0) && (r_pat_len <= LW'(PAT_LEN));
    // Safe subtraction: only consulted when the length is non-zero.
    assign w_fill_ok    = (r_fill >= (r_pat_len - LW'(1)));
    assign w_prog_match = w_len_ok && w_fill_ok && (((w_window ^ r_pat) & w_mask) == '0);

    // Programmable engine: pattern registers, shift history and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat     <= '0;
            r_pat_len <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (pat_load) begin
            r_pat     <= pat_value;
            r_pat_len <= pat_len;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (ena) begin
            r_hist <= w_window[PAT_LEN-2:0];
            if (w_prog_match && !overlap) begin
                r_fill <= '0;
            end else if (r_fill != LW'(PAT_LEN)) begin
                r_fill <= r_fill + LW'(1);
            end
        end
    end

    assign z = ena & ~pat_load & ~rst & (mode ? w_prog_match : w_fix_match);

    // BCD increment with per-digit carry, plus detection of the all-nines ceiling.
    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        w_at_max    = 1'b1;
        w_digit     = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_digit = r_count[4*k +: 4];
            if (w_digit != 4'd9) begin
                w_at_max = 1'b0;
            end
            if (w_carry) begin
                if (w_digit == 4'd9) begin
                    w_count_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*k +: 4] = w_digit + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    // Match counter: clear beats a same-cycle match, and the count holds at all nines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (z && !w_at_max) begin
            r_count <= w_count_inc;
        end
    end

    assign count_bcd = r_count;
    assign saturated = w_at_max;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_disp
        assign disp[7*k +: 7] = seg7(r_count[4*k +: 4]);
    end
endmodule

// File: tb/tb_seq_detector_gen.sv
// Directed bench for seq_detector_gen: a two-digit instance and a one-digit instance share all inputs.
// Latency: z checked mid-cycle on the driven bit; counter/display checked after the capturing edge.
// Backpressure: none; ena is driven directly by the stimulus sequence.
module tb_seq_detector_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        sig_to_test;
    logic        mode;
    logic        overlap;
    logic        pat_load;
    logic [7:0]  pat_value;
    logic [3:0]  pat_len;
    logic        count_clr;
    logic        z;
    logic [7:0]  count_bcd;
    logic [13:0] disp;
    logic        saturated;
    logic        z1;
    logic [3:0]  count1;
    logic [6:0]  disp1;
    logic        sat1;

    int checks = 0;
    int errors = 0;
    bit sb[$];

    always #5 clk = ~clk;

    seq_detector_gen #(.PAT_LEN(8), .NUM_DIGITS(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig_to_test), .mode(mode),
        .overlap(overlap), .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len),
        .count_clr(count_clr), .z(z), .count_bcd(count_bcd), .disp(disp), .saturated(saturated)
    );

    seq_detector_gen #(.PAT_LEN(8), .NUM_DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig_to_test), .mode(mode),
        .overlap(overlap), .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len),
        .count_clr(count_clr), .z(z1), .count_bcd(count1), .disp(disp1), .saturated(sat1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one bit, queue its expected z, and compare mid-cycle before the capturing edge.
    task automatic step(input bit s, input bit ez, input string tag);
        bit e;
        sig_to_test = s;
        sb.push_back(ez);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, "/z"}, z, e);
        chk({tag, "/z1"}, z1, e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input string bits, input string exp, input string tag);
        for (int i = 0; i < bits.len(); i++) begin
            step(bits[i] == "1", exp[i] == "1", $sformatf("%s[%0d]", tag, i + 1));
        end
    endtask

    // One idle cycle that loads a pattern and clears both counters.
    task automatic load_pat(input logic [7:0] v, input logic [3:0] l);
        ena       = 1'b0;
        pat_load  = 1'b1;
        pat_value = v;
        pat_len   = l;
        count_clr = 1'b1;
        cyc();
        pat_load  = 1'b0;
        count_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; sig_to_test = 1'b0; mode = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_value = '0; pat_len = '0; count_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_z", z, 1'b0);
        chk("rst_count", count_bcd, 8'h00);
        chk("rst_disp", disp, {7'h40, 7'h40});
        chk("rst_sat", saturated, 1'b0);
        chk("rst_count1", count1, 4'h0);
        chk("rst_disp1", disp1, 7'h40);
        chk("rst_sat1", sat1, 1'b0);

        // Fixed engine, overlapping.
        ena = 1'b1; mode = 1'b0; overlap = 1'b1;
        run_stream("000100110001011101010011", "000000110000011000010011", "fix_ov");
        chk("fix_ov_count", count_bcd, 8'h07);
        chk("fix_ov_disp", disp, {7'h40, 7'h78});
        chk("fix_ov_count1", count1, 4'h7);
        chk("fix_ov_disp1", disp1, 7'h78);

        ena = 1'b0; count_clr = 1'b1;
        cyc();
        count_clr = 1'b0;
        chk("clr_idle_count", count_bcd, 8'h00);

        // Fixed engine, non-overlapping.
        ena = 1'b1; overlap = 1'b0;
        run_stream("000100110001011101010011", "000000100000010000010001", "fix_nov");
        chk("fix_nov_count", count_bcd, 8'h04);
        chk("fix_nov_disp", disp, {7'h40, 7'h19});

        // Programmable engine, pattern 1011.
        load_pat(8'b00001011, 4'd4);
        mode = 1'b1; overlap = 1'b1; ena = 1'b1;
        run_stream("1011011", "0001001", "prog_ov");
        chk("prog_ov_count", count_bcd, 8'h02);
        load_pat(8'b00001011, 4'd4);
        overlap = 1'b0; ena = 1'b1;
        run_stream("1011011", "0001000", "prog_nov");
        chk("prog_nov_count", count_bcd, 8'h01);

        // Lengths 0 and above PAT_LEN never match.
        load_pat(8'hFF, 4'd0);
        ena = 1'b1; overlap = 1'b1;
        run_stream("111", "000", "len0");
        load_pat(8'hFF, 4'd9);
        ena = 1'b1;
        run_stream("1111111111", "0000000000", "len9");

        // Saturation on the one-digit instance with a single-bit pattern.
        load_pat(8'h01, 4'd1);
        ena = 1'b1;
        run_stream("11111111111", "11111111111", "sat");
        chk("sat_count1", count1, 4'h9);
        chk("sat_flag1", sat1, 1'b1);
        chk("sat_disp1", disp1, 7'h10);
        chk("sat_count", count_bcd, 8'h11);
        chk("sat_flag", saturated, 1'b0);
        ena = 1'b0; count_clr = 1'b1;
        cyc();
        count_clr = 1'b0;
        chk("sat_clr_count1", count1, 4'h0);
        chk("sat_clr_flag1", sat1, 1'b0);

        // Clear wins over a same-cycle match.
        ena = 1'b1; count_clr = 1'b1;
        step(1'b1, 1'b1, "clr_hit");
        count_clr = 1'b0;
        chk("clr_hit_count", count_bcd, 8'h00);
        chk("clr_hit_count1", count1, 4'h0);

        // Hold with ena=0 from S_010, then resume.
        load_pat(8'h00, 4'd0);
        mode = 1'b0; overlap = 1'b0; ena = 1'b1;
        run_stream("010", "000", "hold_pre");
        ena = 1'b0;
        run_stream("111", "000", "hold_off");
        chk("hold_off_count", count_bcd, 8'h00);
        ena = 1'b1;
        step(1'b1, 1'b1, "hold_resume");
        chk("hold_resume_count", count_bcd, 8'h01);

        // Reset from S_010 returns to IDLE.
        run_stream("010", "000", "rst_pre");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_count", count_bcd, 8'h00);
        step(1'b1, 1'b0, "rst_after");
        run_stream("011", "001", "rst_idle");
        chk("rst_idle_count", count_bcd, 8'h01);

        // Load on the cycle a match would complete.
        load_pat(8'b00001011, 4'd4);
        mode = 1'b1; overlap = 1'b1; ena = 1'b1;
        run_stream("101", "000", "ld_pre");
        pat_load = 1'b1;
        step(1'b1, 1'b0, "ld_cycle");
        pat_load = 1'b0;
        chk("ld_cycle_count", count_bcd, 8'h00);
        run_stream("1011", "0001", "ld_post");
        chk("ld_post_count", count_bcd, 8'h01);
        chk("ld_post_disp", disp, {7'h40, 7'h79});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detector_gen.md
Name: seq_detector_gen

Overview:
- Parametrised successor to the fixed 01[0*]1 Mealy detector.
- Two match engines run in parallel on a serial input:
  - a fixed 01[0*]1 FSM;
  - a runtime-programmable exact-pattern matcher, up to PAT_LEN bits.
- Engine select, overlap/non-overlap mode and a saturating NUM_DIGITS-digit BCD match counter.
- Drives active-low 7-segment digits. Sits between the serial input pin and the board display.

Parameters:
- PAT_LEN, 8: maximum programmable pattern length in bits (2..16).
- NUM_DIGITS, 2: number of BCD counter digits and 7-segment displays (1..4).

Ports:
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  1 = process sig_to_test this cycle; 0 = hold all state.
- sig_to_test  in  1  serial bit under test.
- mode  in  1  0 = fixed 01[0*]1 engine drives z; 1 = programmable engine drives z.
- overlap  in  1  1 = overlapping matches allowed; 0 = restart after a match.
- pat_load  in  1  latch pat_value/pat_len into the pattern registers.
- pat_value  in  PAT_LEN  pattern; bit [pat_len-1] is received first, bit [0] last.
- pat_len  in  $clog2(PAT_LEN+1)  active pattern length.
- count_clr  in  1  synchronous clear of the match counter.
- z  out  1  Mealy match flag.
- count_bcd  out  4*NUM_DIGITS  BCD match count; digit k is at [4k+3:4k].
- disp  out  7*NUM_DIGITS  7-seg for digit k at [7k+6:7k], order {g,f,e,d,c,b,a}, active-low.
- saturated  out  1  count held at its maximum.

Behaviour:
- Reset (rst=1, highest priority):
  - Fixed FSM goes to IDLE; history and fill count are cleared.
  - Pattern registers are cleared to value 0, length 0.
  - count_bcd=0, saturated=0, z=0.
  - disp shows "0" on every digit (7'h40).
- ena=0: no state changes, z=0, sig_to_test ignored. Pattern load and count_clr still act.
- z is combinational: z = ena & (selected engine matches on the current sig_to_test). The counter increments on the same rising edge.
- Both engines update every ena cycle regardless of mode, so switching mode is glitch-free and loses no history.
- Fixed engine states: IDLE, S_0 (seen 0), S_01 (seen 01), S_010 (seen 01 plus one or more 0s).
  - IDLE: 0 -> S_0; 1 -> IDLE.
  - S_0: 0 -> S_0; 1 -> S_01.
  - S_01: 0 -> S_010; 1 -> match, then IDLE.
  - S_010: 0 -> S_010; 1 -> match, then S_01 if overlap=1, else IDLE.
- Programmable engine:
  - Shift history of the last PAT_LEN-1 bits plus a fill counter (saturates at PAT_LEN).
  - Match when {hist[pat_len-2:0], sig_to_test} == pat_value[pat_len-1:0] and fill >= pat_len-1.
  - pat_len=1 compares sig_to_test with pat_value[0] only.
  - pat_len=0 or pat_len>PAT_LEN never matches.
  - On a match with overlap=0, fill is cleared to 0 (history is kept but gated by fill).
- pat_load=1:
  - Registers pat_value/pat_len; clears history and fill; fixed FSM goes to IDLE.
  - z=0 in the load cycle. The new pattern applies from the next cycle. The counter is untouched.
- Counter: NUM_DIGITS-digit BCD incrementer with per-digit 9->0 carry.
  - At 10^NUM_DIGITS-1 it holds and saturated=1. z still pulses.
  - count_clr clears count and saturated. If count_clr and a match occur in the same cycle, the result is count=0.
- disp is decoded combinationally from the count register (0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10 for 0..9). It updates in the cycle after z.

Test Plan:
- Fixed, overlap=1, ena=1: stream 000100110001011101010011 (first bit first) after reset -> z high at bits 7,8,14,15,20,23,24; final count_bcd=8'h07; disp={7'h40,7'h78}.
- Fixed, overlap=0: same stream -> z at bits 7,14,20,24; count_bcd=8'h04; disp={7'h40,7'h19}.
- Programmable, pat_load with pat_value=8'b00001011, pat_len=4, stream 1011011: overlap=1 -> z at bits 4,7 (count 2); overlap=0 -> z at bit 4 only (count 1).
- Saturation, NUM_DIGITS=1, mode=1, pattern "1" (pat_len=1), 11 consecutive 1s -> z pulses 11 times, count_bcd=4'h9, saturated=1. Then count_clr -> count 0, saturated 0.
- Hold and reset mid-run:
  - Fixed: drive 0,1,0 to reach S_010, drop ena for 3 cycles with sig=1 -> z=0, count unchanged. Restore ena with 1 -> match.
  - Repeat to S_010, then pulse rst, then drive 1 -> no match; state stays IDLE.
- Load mid-stream: pat_load asserted on the cycle a match would complete -> z=0, count unchanged; a full new pattern is required before the next z.
